// File: rtl/mld_7_3_serial_decoder.sv
// Serial one-step majority-logic decoder for the (7,3) cyclic code g(x)=1+x^2+x^3+x^4.
// Latency: first corrected bit the cycle after c0 is accepted; 7 decode cycles + 1 done cycle.
// Backpressure: out_ready low freezes the current position; no input is taken until the block is done.
module mld_7_3_serial_decoder #(
    parameter bit OUT_INFO_ONLY = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic out_valid,
    output logic out_bit,
    input  logic out_ready,
    output logic blk_done,
    output logic err_corrected,
    output logic err_detected
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0] state;
    logic [2:0] count;
    logic [2:0] idx;
    logic [6:0] r;
    logic       tie_flag;
    logic       flip_flag;

    logic       a1;
    logic       a2;
    logic       a3;
    logic [2:0] votes;
    logic       decision;
    logic       pos_tie;
    logic       pos_flip;
    logic       emit;
    logic       advance;

    // Cyclic index (i + k) mod 7, valid for i in 0..6 and k in 1..6.
    function automatic logic [2:0] mod7(input logic [2:0] i, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, i} + {1'b0, k};
        if (s >= 4'd7) begin
            s = s - 4'd7;
        end
        return s[2:0];
    endfunction

    always_comb begin
        a1       = r[mod7(idx, 3'd1)] ^ r[mod7(idx, 3'd3)];
        a2       = r[mod7(idx, 3'd2)] ^ r[mod7(idx, 3'd6)];
        a3       = r[mod7(idx, 3'd4)] ^ r[mod7(idx, 3'd5)];
        votes    = {2'b00, r[idx]} + {2'b00, a1} + {2'b00, a2} + {2'b00, a3};
        pos_tie  = (votes == 3'd2);
        decision = r[idx];
        if (votes >= 3'd3) begin
            decision = 1'b1;
        end else if (votes <= 3'd1) begin
            decision = 1'b0;
        end
        pos_flip = (decision != r[idx]);
    end

    always_comb begin
        emit      = (OUT_INFO_ONLY == 1'b0) || (idx >= 3'd4);
        in_ready  = (state == ST_LOAD);
        out_valid = (state == ST_DECODE) && emit;
        out_bit   = out_valid ? decision : 1'b0;
        blk_done  = (state == ST_DONE);
        // Non-emitted positions still take one cycle each so block timing is fixed.
        advance   = (state == ST_DECODE) && (!emit || out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_LOAD;
            count         <= 3'd0;
            idx           <= 3'd0;
            r             <= 7'd0;
            tie_flag      <= 1'b0;
            flip_flag     <= 1'b0;
            err_corrected <= 1'b0;
            err_detected  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r[3'd6 - count] <= in_bit;
                        count           <= count + 3'd1;
                        if (count == 3'd6) begin
                            state <= ST_DECODE;
                            idx   <= 3'd6;
                        end
                    end
                end
                ST_DECODE: begin
                    if (advance) begin
                        tie_flag  <= tie_flag | pos_tie;
                        flip_flag <= flip_flag | pos_flip;
                        if (idx == 3'd0) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx - 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    err_detected  <= tie_flag;
                    err_corrected <= flip_flag & ~tie_flag;
                    tie_flag      <= 1'b0;
                    flip_flag     <= 1'b0;
                    count         <= 3'd0;
                    state         <= ST_LOAD;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mld_7_3_serial_decoder.sv
// Directed bench: two decoders (all bits / info bits only) fed the same stream,
// expected bits and status queued at send time and checked by a monitor.
module tb_mld_7_3_serial_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b1;

    logic in_ready0, out_valid0, out_bit0, blk_done0, err_corrected0, err_detected0;
    logic in_ready1, out_valid1, out_bit1, blk_done1, err_corrected1, err_detected1;

    mld_7_3_serial_decoder #(.OUT_INFO_ONLY(1'b0)) dut0 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_bit(out_bit0), .out_ready(out_ready), .blk_done(blk_done0),
        .err_corrected(err_corrected0), .err_detected(err_detected0)
    );

    mld_7_3_serial_decoder #(.OUT_INFO_ONLY(1'b1)) dut1 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_bit(out_bit1), .out_ready(out_ready), .blk_done(blk_done1),
        .err_corrected(err_corrected1), .err_detected(err_detected1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic       q0[$];
    logic       q1[$];
    logic [1:0] qe0[$];
    logic [1:0] qe1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: beats compared on handshake, status checked the cycle after blk_done.
    int         gap0 = 0;
    int         gap1 = 0;
    logic       pend0 = 1'b0;
    logic       pend1 = 1'b0;
    logic [1:0] pe0;
    logic [1:0] pe1;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
            gap0  = 0;
            gap1  = 0;
        end else begin
            if (pend0) begin
                check("status0", {err_corrected0, err_detected0}, pe0);
                pend0 = 1'b0;
            end
            if (pend1) begin
                check("status1", {err_corrected1, err_detected1}, pe1);
                pend1 = 1'b0;
            end
            gap0++;
            gap1++;
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) fail_now("unexpected_beat0");
                else check("bit0", out_bit0, q0.pop_front());
                gap0 = 0;
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) fail_now("unexpected_beat1");
                else check("bit1", out_bit1, q1.pop_front());
                gap1 = 0;
            end
            if (blk_done0) begin
                check("done_gap0", gap0, 1);
                if (qe0.size() == 0) fail_now("unexpected_done0");
                else begin
                    pe0   = qe0.pop_front();
                    pend0 = 1'b1;
                end
            end
            if (blk_done1) begin
                check("done_gap1", gap1, 5);
                if (qe1.size() == 0) fail_now("unexpected_done1");
                else begin
                    pe1   = qe1.pop_front();
                    pend1 = 1'b1;
                end
            end
        end
    end

    // Sends the first n bits of w (c6 first); full blocks queue corrected word c and status e={corr,det}.
    task automatic send(input logic [6:0] w, input logic [6:0] c, input logic [1:0] e,
                        input int n, input bit hold);
        int guard;
        if (n == 7) begin
            for (int b = 6; b >= 0; b--) q0.push_back(c[b]);
            for (int b = 6; b >= 4; b--) q1.push_back(c[b]);
            qe0.push_back(e);
            qe1.push_back(e);
        end
        for (int b = 6; b > 6 - n; b--) begin
            guard = 0;
            while (!in_ready0 && guard < 100) begin
                in_bit = ~w[b];
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) fail_now("in_ready_timeout");
            in_valid = 1'b1;
            in_bit   = w[b];
            @(negedge clk);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0 || qe0.size() != 0 || qe1.size() != 0 ||
                pend0 || pend1) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) fail_now("drain_timeout");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_bit", out_bit0, 0);
        check("rst_blk_done", blk_done0, 0);
        check("rst_err", {err_corrected0, err_detected0}, 0);
        check("rst_out_valid1", out_valid1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(7'b1010011, 7'b1010011, 2'b00, 7, 1'b0);
        send(7'b1010111, 7'b1010011, 2'b10, 7, 1'b0);
        send(7'b0011011, 7'b0011011, 2'b01, 7, 1'b0);
        send(7'b0010011, 7'b1010011, 2'b10, 7, 1'b0);
        wait_idle();

        // Stall on the second beat for four cycles.
        send(7'b1010011, 7'b1010011, 2'b00, 7, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("stall_bit", out_bit0, 0);
            check("stall_valid", out_valid0, 1);
            check("stall_in_ready", in_ready0, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a block after a status-setting block.
        send(7'b0011011, 7'b0011011, 2'b01, 7, 1'b0);
        wait_idle();
        send(7'b1100000, 7'b0000000, 2'b00, 4, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_err", {err_corrected0, err_detected0}, 0);
        check("midrst_in_ready", in_ready0, 1);
        check("midrst_out_valid", out_valid0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(7'b1010111, 7'b1010011, 2'b10, 7, 1'b0);
        check("fresh_err_before_done", {err_corrected0, err_detected0}, 0);
        wait_idle();

        // Back-to-back with in_valid held high across blocks.
        send(7'b1010111, 7'b1010011, 2'b10, 7, 1'b1);
        send(7'b0011011, 7'b0011011, 2'b01, 7, 1'b1);
        send(7'b1010011, 7'b1010011, 2'b00, 7, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        check("queues_empty", q0.size() + q1.size() + qe0.size() + qe1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
